// File: rtl/bcd_digit_entry_pkg.sv
// Shared calculator definitions for the digit-entry front end.
package bcd_digit_entry_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ENTRY = 1'b0,
    OFFER = 1'b1
  } entry_state_t;

endpackage

// File: rtl/bcd_digit_entry_if.sv
// Board-side and downstream signals of the digit-entry block.
// The slave modport is the entry block itself; the master modport is
// whatever drives the board inputs and consumes the operand.
interface bcd_digit_entry_if #(
  parameter int NUM_DIGITS = 4
);
  import bcd_digit_entry_pkg::*;

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [BCD_W-1:0]            sw_digit;
  logic                        btn_enter;
  logic                        btn_clear;
  logic                        btn_done;
  logic [BCD_W*NUM_DIGITS-1:0] bcd_value;
  logic [CNT_W-1:0]            digit_count;
  logic                        valid;
  logic                        ready;
  logic                        err;

  modport slave (
    input  sw_digit, btn_enter, btn_clear, btn_done, ready,
    output bcd_value, digit_count, valid, err
  );

  modport master (
    output sw_digit, btn_enter, btn_clear, btn_done, ready,
    input  bcd_value, digit_count, valid, err
  );

endinterface

// File: rtl/bcd_digit_entry_button_debounce.sv
// Synchronizes one raw push-button, debounces it, and emits a single-cycle
// pulse when the accepted level goes from 0 to 1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             level_prev;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer, then a run-length counter that only flips the
  // level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      level_prev <= level;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/bcd_digit_entry.sv
// Collects BCD digits from the switches one ENTER press at a time and offers
// the finished operand downstream with a valid/ready handshake.
module bcd_digit_entry
  import bcd_digit_entry_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                  clk,
  input logic                  reset,
  bcd_digit_entry_if.slave     bus
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int VAL_W = BCD_W * NUM_DIGITS;

  logic             p_enter;
  logic             p_clear;
  logic             p_done;
  logic             lvl_enter;
  logic             lvl_clear;
  logic             lvl_done;
  logic             unused_levels;

  logic [BCD_W-1:0] sw_sync1;
  logic [BCD_W-1:0] sw_sync2;

  entry_state_t     state_q;
  entry_state_t     state_n;
  logic [VAL_W-1:0] value_q;
  logic [VAL_W-1:0] value_n;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic             err_q;
  logic             err_n;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_enter),
    .level   (lvl_enter),
    .rise    (p_enter)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_clear),
    .level   (lvl_clear),
    .rise    (p_clear)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_done (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_done),
    .level   (lvl_done),
    .rise    (p_done)
  );

  // Debounced levels are only needed as pulses here.
  assign unused_levels = ^{lvl_enter, lvl_clear, lvl_done};

  // Bring the switch digit into the clock domain before it is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= bus.sw_digit;
      sw_sync2 <= sw_sync1;
    end
  end

  // Entry state, operand, digit count and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      value_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      value_q <= value_n;
      count_q <= count_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic: clear beats done beats enter, and lower-priority
  // pulses arriving in the same cycle are simply dropped.
  always_comb begin
    state_n = state_q;
    value_n = value_q;
    count_n = count_q;
    err_n   = err_q;
    if (p_clear) begin
      state_n = ENTRY;
      value_n = '0;
      count_n = '0;
      err_n   = 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (p_done) begin
            if (count_q != '0) begin
              state_n = OFFER;
            end
          end else if (p_enter) begin
            if (sw_sync2 > BCD_MAX) begin
              err_n = 1'b1;
            end else if (count_q == CNT_W'(NUM_DIGITS)) begin
              err_n = 1'b1;
            end else begin
              value_n              = value_q << BCD_W;
              value_n[BCD_W-1:0]   = sw_sync2;
              count_n              = count_q + CNT_W'(1);
            end
          end
        end
        OFFER: begin
          if (bus.ready) begin
            state_n = ENTRY;
            value_n = '0;
            count_n = '0;
          end
        end
        default: state_n = ENTRY;
      endcase
    end
  end

  assign bus.bcd_value   = value_q;
  assign bus.digit_count = count_q;
  assign bus.valid       = (state_q == OFFER);
  assign bus.err         = err_q;

endmodule
